scale_ratio_sequencer: RTL and testbench

Upstream control stage for the division_processor divider in the image scaler datapath.
- On a start request it forms fixed-point scale ratios src_w/dst_w and src_h/dst_h by issuing two sequential requests to the divider.
- It collects each quotient, then presents both ratios with a done pulse to the coordinate-stepping logic.
- It guards against zero divisors and a hung divider.

---
 rtl/scale_ratio_sequencer_if.sv | 11 +
 rtl/scale_ratio_sequencer.sv | 140 ++++++++++++++
 tb/tb_scale_ratio_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scale_ratio_sequencer_if.sv
// Request/response bus between the ratio sequencer and the divider.
interface scale_ratio_sequencer_if;
  logic [15:0] div_data1;
  logic [15:0] div_data2;
  logic        div_rdy;
  logic [15:0] div_out;
  logic        div_out_rdy;

  modport master (output div_data1, div_data2, div_rdy, input div_out, div_out_rdy);
  modport slave  (input div_data1, div_data2, div_rdy, output div_out, div_out_rdy);
endinterface

// File: rtl/scale_ratio_sequencer.sv
// Forms fixed-point scale ratios src/dst for width then height by issuing two
// sequential divider requests, guarding against zero divisors and a hung divider.
module scale_ratio_sequencer #(
  parameter int  FRAC_BITS   = 6,
  parameter int  TIMEOUT_CYC = 64,
  localparam int DIM_W       = 16 - FRAC_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DIM_W-1:0]         src_w,
  input  logic [DIM_W-1:0]         dst_w,
  input  logic [DIM_W-1:0]         src_h,
  input  logic [DIM_W-1:0]         dst_h,
  scale_ratio_sequencer_if.master  div,
  output logic [15:0]              ratio_x,
  output logic [15:0]              ratio_y,
  output logic                     busy,
  output logic                     done,
  output logic                     err_zero,
  output logic                     err_timeout
);
  localparam int             CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, REQ_X, WAIT_X, REQ_Y, WAIT_Y, FIN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  // Width dims go straight into the request registers at acceptance; only the
  // height pair has to survive until the second request.
  logic [DIM_W-1:0] src_h_q, dst_h_q, src_h_n, dst_h_n;
  logic [15:0]      data1_n, data2_n, rx_n, ry_n;
  logic             rdy_n, done_n, ez_n, et_n;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_n = state;
    // Counter runs through REQ and WAIT so a wait aborts TIMEOUT_CYC cycles after its request.
    cnt_n   = (state == IDLE || state == FIN) ? '0 : cnt + CNT_W'(1);
    data1_n = div.div_data1;
    data2_n = div.div_data2;
    rdy_n   = 1'b0;
    done_n  = 1'b0;
    rx_n    = ratio_x;
    ry_n    = ratio_y;
    ez_n    = err_zero;
    et_n    = err_timeout;
    src_h_n = src_h_q;
    dst_h_n = dst_h_q;
    case (state)
      IDLE: if (start) begin
        src_h_n = src_h;
        dst_h_n = dst_h;
        rx_n    = '0;
        ry_n    = '0;
        ez_n    = 1'b0;
        et_n    = 1'b0;
        if (dst_w == '0 || dst_h == '0) begin
          ez_n    = 1'b1;
          state_n = FIN;
          done_n  = 1'b1;
        end else begin
          state_n = REQ_X;
          rdy_n   = 1'b1;
          data1_n = {src_w, {FRAC_BITS{1'b0}}};
          data2_n = {{FRAC_BITS{1'b0}}, dst_w};
          cnt_n   = '0;
        end
      end
      REQ_X: state_n = WAIT_X;
      WAIT_X: begin
        // A result on the last allowed cycle beats the timeout.
        if (div.div_out_rdy) begin
          rx_n    = div.div_out;
          state_n = REQ_Y;
          rdy_n   = 1'b1;
          data1_n = {src_h_q, {FRAC_BITS{1'b0}}};
          data2_n = {{FRAC_BITS{1'b0}}, dst_h_q};
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          et_n    = 1'b1;
          state_n = FIN;
          done_n  = 1'b1;
        end
      end
      REQ_Y: state_n = WAIT_Y;
      WAIT_Y: begin
        if (div.div_out_rdy) begin
          ry_n    = div.div_out;
          state_n = FIN;
          done_n  = 1'b1;
        end else if (cnt == CNT_LAST) begin
          et_n    = 1'b1;
          state_n = FIN;
          done_n  = 1'b1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output and datapath registers; outputs track the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      src_h_q       <= '0;
      dst_h_q       <= '0;
      div.div_data1 <= '0;
      div.div_data2 <= '0;
      div.div_rdy   <= 1'b0;
      ratio_x       <= '0;
      ratio_y       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_zero      <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      cnt           <= cnt_n;
      src_h_q       <= src_h_n;
      dst_h_q       <= dst_h_n;
      div.div_data1 <= data1_n;
      div.div_data2 <= data2_n;
      div.div_rdy   <= rdy_n;
      ratio_x       <= rx_n;
      ratio_y       <= ry_n;
      busy          <= (state_n != IDLE);
      done          <= done_n;
      err_zero      <= ez_n;
      err_timeout   <= et_n;
    end
  end
endmodule

// File: tb/tb_scale_ratio_sequencer.sv
// Bench for scale_ratio_sequencer: the bench plays the divider, answering each
// request with floor((src << FRAC_BITS) / dst) after a chosen latency.
module tb_scale_ratio_sequencer;
  localparam int FB = 6;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  src_w = '0, dst_w = '0, src_h = '0, dst_h = '0;
  logic [15:0] ratio_x, ratio_y;
  logic        busy, done, err_zero, err_timeout;
  int          checks = 0;
  int          errors = 0;

  scale_ratio_sequencer_if dif();

  scale_ratio_sequencer #(.FRAC_BITS(FB), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_w(src_w), .dst_w(dst_w), .src_h(src_h), .dst_h(dst_h),
    .div(dif),
    .ratio_x(ratio_x), .ratio_y(ratio_y), .busy(busy), .done(done),
    .err_zero(err_zero), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called while observing a REQ cycle. j==0: never answer, count cycles to done.
  task automatic respond(input int j, input logic [15:0] q, input bit stray,
                         output int cyc, output bit bad);
    bad = 1'b0;
    cyc = 0;
    if (j == 0) begin
      do begin
        tick();
        cyc++;
        if (dif.div_rdy) bad = 1'b1;
      end while (!done && cyc < 200);
    end else begin
      for (int i = 1; i <= j; i++) begin
        if (i == 1 && stray) begin
          dif.div_out     = q + 16'd1234;
          dif.div_out_rdy = 1'b1;
        end
        tick();
        dif.div_out_rdy = 1'b0;
        if (dif.div_rdy || done || !busy) bad = 1'b1;
      end
      dif.div_out     = q;
      dif.div_out_rdy = 1'b1;
      tick();
      dif.div_out_rdy = 1'b0;
      dif.div_out     = 16'($urandom);
    end
  endtask

  // One full computation; ends observing the IDLE cycle after FIN.
  task automatic do_run(input string nm, input int sw, input int dw, input int sh, input int dh,
                        input int jx, input int jy, input bit hold, input bit stray);
    int          s[2], d[2], j[2];
    logic [15:0] q[2];
    logic [15:0] ex_rx, ex_ry;
    int          cyc;
    bit          bad, to;
    s = '{sw, sh};
    d = '{dw, dh};
    j = '{jx, jy};
    q[0] = (dw != 0) ? 16'((sw * (1 << FB)) / dw) : 16'd0;
    q[1] = (dh != 0) ? 16'((sh * (1 << FB)) / dh) : 16'd0;
    ex_rx = 16'd0;
    ex_ry = 16'd0;
    src_w = 10'(sw); dst_w = 10'(dw); src_h = 10'(sh); dst_h = 10'(dh);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    if (dw == 0 || dh == 0) begin
      checks++;
      if ({done, busy, err_zero, err_timeout, dif.div_rdy} !== 5'b11100 || ratio_x !== 16'd0 || ratio_y !== 16'd0) begin
        errors++;
        $display("FAIL %s zero_div: done/busy/ez/et/rdy=%b rx=%0d ry=%0d, want 11100 rx=0 ry=0",
                 nm, {done, busy, err_zero, err_timeout, dif.div_rdy}, ratio_x, ratio_y);
      end
      tick();
      checks++;
      if ({done, busy, dif.div_rdy, err_zero} !== 4'b0001) begin
        errors++;
        $display("FAIL %s zero_idle: done/busy/rdy/ez=%b, want 0001", nm, {done, busy, dif.div_rdy, err_zero});
      end
      return;
    end
    to = 1'b0;
    for (int ph = 0; ph < 2 && !to; ph++) begin
      checks++;
      if ({dif.div_rdy, done, busy, err_zero, err_timeout} !== 5'b10100 ||
          dif.div_data1 !== 16'(s[ph] * (1 << FB)) || dif.div_data2 !== 16'(d[ph]) ||
          ratio_x !== ex_rx || ratio_y !== ex_ry) begin
        errors++;
        $display("FAIL %s req%0d: rdy/done/busy/ez/et=%b d1=%0d d2=%0d rx=%0d, want 10100 d1=%0d d2=%0d rx=%0d",
                 nm, ph, {dif.div_rdy, done, busy, err_zero, err_timeout}, dif.div_data1, dif.div_data2,
                 ratio_x, 16'(s[ph] * (1 << FB)), d[ph], ex_rx);
      end
      respond(j[ph], q[ph], stray && ph == 1, cyc, bad);
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s wait%0d: div_rdy/done/busy wrong while waiting, want 0/0/1", nm, ph);
      end
      if (j[ph] == 0) begin
        to = 1'b1;
        checks++;
        if (cyc !== TO || {done, busy, err_timeout, err_zero} !== 4'b1110 || ratio_x !== ex_rx || ratio_y !== 16'd0) begin
          errors++;
          $display("FAIL %s timeout%0d: cycles=%0d done/busy/et/ez=%b rx=%0d, want %0d 1110 rx=%0d",
                   nm, ph, cyc, {done, busy, err_timeout, err_zero}, ratio_x, TO, ex_rx);
        end
      end else if (ph == 0) ex_rx = q[0];
      else ex_ry = q[1];
    end
    if (!to) begin
      checks++;
      if ({done, busy, err_timeout, err_zero, dif.div_rdy} !== 5'b11000 || ratio_x !== q[0] || ratio_y !== q[1]) begin
        errors++;
        $display("FAIL %s fin: done/busy/et/ez/rdy=%b rx=%0d ry=%0d, want 11000 rx=%0d ry=%0d",
                 nm, {done, busy, err_timeout, err_zero, dif.div_rdy}, ratio_x, ratio_y, q[0], q[1]);
      end
    end
    tick();
    checks++;
    if ({done, busy, dif.div_rdy, err_timeout} !== {3'b000, to} || ratio_x !== ex_rx || ratio_y !== ex_ry) begin
      errors++;
      $display("FAIL %s idle: done/busy/rdy/et=%b rx=%0d ry=%0d, want %b rx=%0d ry=%0d",
               nm, {done, busy, dif.div_rdy, err_timeout}, ratio_x, ratio_y, {3'b000, to}, ex_rx, ex_ry);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({ratio_x, ratio_y, dif.div_data1, dif.div_data2, busy, done, err_zero, err_timeout, dif.div_rdy} !== '0) begin
      errors++;
      $display("FAIL reset: rx=%0d ry=%0d d1=%0d d2=%0d busy/done/ez/et/rdy=%b, want all 0",
               ratio_x, ratio_y, dif.div_data1, dif.div_data2, {busy, done, err_zero, err_timeout, dif.div_rdy});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_scaling();
    do_run("down_640x480_320x240", 640, 320, 480, 240, 3, 5, 1'b0, 1'b0);
    do_run("up_320x240_640x480", 320, 640, 240, 480, 2, 2, 1'b0, 1'b0);
    do_run("trunc_100_30", 100, 30, 100, 30, 4, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      int a = int'($urandom_range(1, 1023));
      int b = int'($urandom_range(1, 1023));
      do_run("identity", a, a, b, b, int'($urandom_range(1, 10)), int'($urandom_range(1, 10)), 1'b0, 1'b0);
    end
  endtask

  task automatic test_zero();
    do_run("zero_dst_h", 100, 50, 100, 0, 1, 1, 1'b0, 1'b0);
    do_run("zero_dst_w", 100, 0, 100, 50, 1, 1, 1'b0, 1'b0);
    do_run("after_zero", 200, 100, 90, 45, 2, 3, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    do_run("timeout_x", 300, 150, 200, 100, 0, 1, 1'b0, 1'b0);
    do_run("after_timeout", 300, 150, 200, 100, 6, 2, 1'b0, 1'b0);
    do_run("timeout_y", 500, 7, 333, 11, 3, 0, 1'b0, 1'b0);
    do_run("result_on_last_cycle", 1023, 1, 17, 1023, TO - 1, TO - 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit bad = 1'b0;
    src_w = 10'd640; dst_w = 10'd320; src_h = 10'd480; dst_h = 10'd240;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({ratio_x, ratio_y, dif.div_data1, dif.div_data2, busy, done, err_zero, err_timeout, dif.div_rdy} !== '0) begin
      errors++;
      $display("FAIL reset_mid: rx=%0d d1=%0d d2=%0d busy/done/ez/et/rdy=%b, want all 0",
               ratio_x, dif.div_data1, dif.div_data2, {busy, done, err_zero, err_timeout, dif.div_rdy});
    end
    repeat (2) tick();
    dif.div_out     = 16'd128;
    dif.div_out_rdy = 1'b1;
    tick();
    dif.div_out_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy || dif.div_rdy || ratio_x !== 16'd0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stray_after_reset: saw done/busy/div_rdy or ratio_x=%0d, want idle with ratio_x=0", ratio_x);
    end
    do_run("after_reset_mid", 640, 320, 480, 240, 2, 2, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_run("b2b_first", 800, 400, 600, 200, 3, 4, 1'b1, 1'b1);
    do_run("b2b_second", 123, 456, 789, 321, 5, 2, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      do_run("random", int'($urandom_range(1, 1023)), int'($urandom_range(1, 1023)),
             int'($urandom_range(1, 1023)), int'($urandom_range(1, 1023)),
             int'($urandom_range(1, 30)), int'($urandom_range(1, 30)), 1'b0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    dif.div_out     = '0;
    dif.div_out_rdy = 1'b0;
    test_reset();
    test_scaling();
    test_zero();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
